// File: rtl/bus_sync_pkg.sv
// Shared FSM state type and MODE encodings for the bus_sync_hs CDC receiver.
// Imported by the top module; carries no logic of its own.
package bus_sync_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  localparam int MODE_LEVEL  = 0;
  localparam int MODE_TOGGLE = 1;

endpackage

// File: rtl/bus_sync_hs_if.sv
// Bus, qualifier, consumer handshake and overrun status of one bus_sync_hs instance.
// master = source/consumer side, slave = the synchroniser itself.
interface bus_sync_hs_if #(
  parameter int BUS_WIDTH = 8,
  parameter int OVR_CNT_W = 4
);

  logic [BUS_WIDTH-1:0] unsync_bus;
  logic                 bus_enable;
  logic                 sync_ready;
  logic                 ovr_clr;
  logic [BUS_WIDTH-1:0] sync_bus;
  logic                 enable_pulse;
  logic                 sync_valid;
  logic                 ack;
  logic                 overrun;
  logic [OVR_CNT_W-1:0] ovr_count;

  modport master (
    output unsync_bus, bus_enable, sync_ready, ovr_clr,
    input  sync_bus, enable_pulse, sync_valid, ack, overrun, ovr_count
  );

  modport slave (
    input  unsync_bus, bus_enable, sync_ready, ovr_clr,
    output sync_bus, enable_pulse, sync_valid, ack, overrun, ovr_count
  );

endinterface

// File: rtl/sync_chain.sv
// Single-bit NUM_STAGES-flop synchroniser; q follows d after NUM_STAGES edges.
// No backpressure: samples d on every clock edge.
module sync_chain #(
  parameter int NUM_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [NUM_STAGES-1:0] stage_q;
  logic [NUM_STAGES-1:0] stage_d;

  always_comb begin
    stage_d = {stage_q[NUM_STAGES-2:0], d};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign q = stage_q[NUM_STAGES-1];

endmodule

// File: rtl/bus_sync_hs.sv
// CDC bus receiver: synced bus_enable event captures unsync_bus, pulses, holds under valid/ready.
// Latency NUM_STAGES+1 edges; unconsumed data is overwritten by newer events and counted as overrun.
module bus_sync_hs
  import bus_sync_pkg::*;
#(
  parameter int BUS_WIDTH  = 8,
  parameter int NUM_STAGES = 2,
  parameter int MODE       = MODE_LEVEL,
  parameter int OVR_CNT_W  = 4
) (
  input logic          CLK,
  input logic          RST,
  bus_sync_hs_if.slave bif
);

  if (NUM_STAGES < 2) begin : g_chk_stages
    $error("bus_sync_hs: NUM_STAGES must be >= 2");
  end
  if (MODE != MODE_LEVEL && MODE != MODE_TOGGLE) begin : g_chk_mode
    $error("bus_sync_hs: MODE must be 0 (level) or 1 (toggle)");
  end

  localparam logic [OVR_CNT_W-1:0] CNT_MAX = '1;

  logic                 en_sync;
  logic                 evt;
  logic                 ovr_evt;
  state_e               state_q, state_d;
  logic                 prev_q, prev_d;
  logic [BUS_WIDTH-1:0] sync_bus_q, sync_bus_d;
  logic                 pulse_q, pulse_d;
  logic                 overrun_q, overrun_d;
  logic [OVR_CNT_W-1:0] ovr_count_q, ovr_count_d;

  sync_chain #(
    .NUM_STAGES (NUM_STAGES)
  ) u_sync_chain (
    .clk (CLK),
    .rst (RST),
    .d   (bif.bus_enable),
    .q   (en_sync)
  );

  // prev_q lags the last stage by one cycle, so the chain resetting to 0
  // makes an already-high bus_enable look like a fresh edge in both modes.
  assign evt = (MODE == MODE_TOGGLE) ? (en_sync ^ prev_q) : (en_sync & ~prev_q);

  always_comb begin
    state_d    = state_q;
    sync_bus_d = sync_bus_q;
    pulse_d    = evt;
    prev_d     = en_sync;
    ovr_evt    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (evt) begin
          sync_bus_d = bif.unsync_bus;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        if (evt) begin
          sync_bus_d = bif.unsync_bus;
          ovr_evt    = ~bif.sync_ready;
        end else if (bif.sync_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A clear that coincides with a fresh overrun keeps that overrun.
  always_comb begin
    overrun_d   = overrun_q;
    ovr_count_d = ovr_count_q;
    if (bif.ovr_clr) begin
      overrun_d   = ovr_evt;
      ovr_count_d = ovr_evt ? OVR_CNT_W'(1) : '0;
    end else if (ovr_evt) begin
      overrun_d = 1'b1;
      if (ovr_count_q != CNT_MAX) begin
        ovr_count_d = ovr_count_q + OVR_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      prev_q      <= 1'b0;
      sync_bus_q  <= '0;
      pulse_q     <= 1'b0;
      overrun_q   <= 1'b0;
      ovr_count_q <= '0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      sync_bus_q  <= sync_bus_d;
      pulse_q     <= pulse_d;
      overrun_q   <= overrun_d;
      ovr_count_q <= ovr_count_d;
    end
  end

  assign bif.sync_bus     = sync_bus_q;
  assign bif.enable_pulse = pulse_q;
  assign bif.sync_valid   = (state_q == HOLD);
  assign bif.ack          = prev_q;
  assign bif.overrun      = overrun_q;
  assign bif.ovr_count    = ovr_count_q;

endmodule

// File: tb/tb_bus_sync_hs.sv
// Bench for bus_sync_hs: three configurations (N2/level, N4/toggle, N3/toggle with 2-bit counter).
// Vector table, hand-written corner sequences, then random traffic against a delay-line reference.
module tb_bus_sync_hs;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  bus_sync_hs_if #(.BUS_WIDTH(8), .OVR_CNT_W(4)) bif_a ();
  bus_sync_hs_if #(.BUS_WIDTH(8), .OVR_CNT_W(4)) bif_b ();
  bus_sync_hs_if #(.BUS_WIDTH(8), .OVR_CNT_W(2)) bif_c ();

  bus_sync_hs #(.BUS_WIDTH(8), .NUM_STAGES(2), .MODE(0), .OVR_CNT_W(4)) dut_a (
    .CLK(clk), .RST(rst), .bif(bif_a));
  bus_sync_hs #(.BUS_WIDTH(8), .NUM_STAGES(4), .MODE(1), .OVR_CNT_W(4)) dut_b (
    .CLK(clk), .RST(rst), .bif(bif_b));
  bus_sync_hs #(.BUS_WIDTH(8), .NUM_STAGES(3), .MODE(1), .OVR_CNT_W(2)) dut_c (
    .CLK(clk), .RST(rst), .bif(bif_c));

  // Reference: hist[i] is bus_enable as sampled i+1 edges ago, so the synced
  // level seen by an edge is hist[N-1] and the one before it hist[N].
  typedef struct {
    logic [15:0] hist;
    logic [7:0]  data;
    bit          valid;
    bit          pulse;
    bit          ovr;
    bit          ack;
    int          cnt;
  } mdl_t;

  typedef struct {
    bit         be;
    logic [7:0] bus;
    bit         rdy;
    bit         clr;
    bit         pulse;
    bit         valid;
    logic [7:0] q;
    bit         ack;
    bit         ovr;
    int         cnt;
  } vec_t;

  vec_t vq[$];
  mdl_t ma, mb, mc, mz;
  logic [7:0] tdat [3] = '{8'h11, 8'h22, 8'h33};
  int   sat_cnt [10] = '{0, 0, 0, 0, 1, 2, 3, 3, 3, 3};
  int   first_a, n_a, first_b, n_b;
  bit   lvl_b;

  function automatic mdl_t mdl_zero();
    mdl_t m;
    m.hist = '0; m.data = '0; m.valid = 0; m.pulse = 0; m.ovr = 0; m.ack = 0; m.cnt = 0;
    return m;
  endfunction

  function automatic mdl_t mdl_step(mdl_t m, int n, int mode, int cmax,
                                    bit be, logic [7:0] bus, bit rdy, bit clr);
    mdl_t r = m;
    bit cur = m.hist[n-1];
    bit old = m.hist[n];
    bit ev  = (mode == 1) ? (cur != old) : (cur && !old);
    bit oe  = ev && m.valid && !rdy;
    r.hist  = {m.hist[14:0], be};
    r.ack   = cur;
    r.pulse = ev;
    if (ev) begin
      r.data  = bus;
      r.valid = 1;
    end else if (m.valid && rdy) begin
      r.valid = 0;
    end
    if (clr) begin
      r.ovr = oe;
      r.cnt = oe ? 1 : 0;
    end else if (oe) begin
      r.ovr = 1;
      r.cnt = (m.cnt < cmax) ? m.cnt + 1 : cmax;
    end
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cmp(input string tag, input mdl_t m, input logic [7:0] q, input logic p,
                     input logic v, input logic a, input logic o, input int c);
    chk({tag, "_bus"},   int'(q), int'(m.data));
    chk({tag, "_pulse"}, int'(p), int'(m.pulse));
    chk({tag, "_valid"}, int'(v), int'(m.valid));
    chk({tag, "_ack"},   int'(a), int'(m.ack));
    chk({tag, "_ovr"},   int'(o), int'(m.ovr));
    chk({tag, "_cnt"},   c,       m.cnt);
  endtask

  task automatic add_vec(input bit be, input logic [7:0] bus, input bit rdy, input bit clr,
                         input bit pulse, input bit valid, input logic [7:0] q,
                         input bit ack, input bit ovr, input int cnt);
    vec_t v;
    v.be = be; v.bus = bus; v.rdy = rdy; v.clr = clr;
    v.pulse = pulse; v.valid = valid; v.q = q; v.ack = ack; v.ovr = ovr; v.cnt = cnt;
    vq.push_back(v);
  endtask

  task automatic cmp_all(input string tag);
    cmp({tag, "_a"}, mz, bif_a.sync_bus, bif_a.enable_pulse, bif_a.sync_valid, bif_a.ack,
        bif_a.overrun, int'(bif_a.ovr_count));
    cmp({tag, "_b"}, mz, bif_b.sync_bus, bif_b.enable_pulse, bif_b.sync_valid, bif_b.ack,
        bif_b.overrun, int'(bif_b.ovr_count));
    cmp({tag, "_c"}, mz, bif_c.sync_bus, bif_c.enable_pulse, bif_c.sync_valid, bif_c.ack,
        bif_c.overrun, int'(bif_c.ovr_count));
  endtask

  task automatic idle_inputs();
    bif_a.unsync_bus = '0; bif_a.bus_enable = 0; bif_a.sync_ready = 0; bif_a.ovr_clr = 0;
    bif_b.unsync_bus = '0; bif_b.bus_enable = 0; bif_b.sync_ready = 0; bif_b.ovr_clr = 0;
    bif_c.unsync_bus = '0; bif_c.bus_enable = 0; bif_c.sync_ready = 0; bif_c.ovr_clr = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    mz  = mdl_zero();
    rst = 1'b1;
    idle_inputs();

    // be, bus, rdy, clr | pulse, valid, sync_bus, ack, overrun, ovr_count  (DUT A, N=2, level)
    add_vec(1, 8'hA5, 0, 0,  0, 0, 8'h00, 0, 0, 0);
    add_vec(1, 8'hA5, 0, 0,  0, 0, 8'h00, 0, 0, 0);
    add_vec(1, 8'hA5, 0, 0,  1, 1, 8'hA5, 1, 0, 0);
    add_vec(1, 8'hA5, 0, 0,  0, 1, 8'hA5, 1, 0, 0);
    add_vec(1, 8'hA5, 1, 0,  0, 0, 8'hA5, 1, 0, 0);
    add_vec(0, 8'h5A, 0, 0,  0, 0, 8'hA5, 1, 0, 0);
    add_vec(0, 8'h5A, 0, 0,  0, 0, 8'hA5, 1, 0, 0);
    add_vec(0, 8'h5A, 0, 0,  0, 0, 8'hA5, 0, 0, 0);
    add_vec(1, 8'hAA, 0, 0,  0, 0, 8'hA5, 0, 0, 0);
    add_vec(0, 8'hAA, 0, 0,  0, 0, 8'hA5, 0, 0, 0);
    add_vec(1, 8'hAA, 0, 0,  1, 1, 8'hAA, 1, 0, 0);
    add_vec(0, 8'hBB, 0, 0,  0, 1, 8'hAA, 0, 0, 0);
    add_vec(1, 8'hBB, 0, 0,  1, 1, 8'hBB, 1, 1, 1);
    add_vec(0, 8'hCC, 0, 0,  0, 1, 8'hBB, 0, 1, 1);
    add_vec(0, 8'hCC, 0, 0,  1, 1, 8'hCC, 1, 1, 2);
    add_vec(0, 8'hCC, 0, 0,  0, 1, 8'hCC, 0, 1, 2);
    add_vec(0, 8'hCC, 0, 1,  0, 1, 8'hCC, 0, 0, 0);
    add_vec(0, 8'hCC, 1, 0,  0, 0, 8'hCC, 0, 0, 0);
    add_vec(1, 8'hDD, 0, 0,  0, 0, 8'hCC, 0, 0, 0);
    add_vec(0, 8'hDD, 0, 0,  0, 0, 8'hCC, 0, 0, 0);
    add_vec(0, 8'hDD, 0, 0,  1, 1, 8'hDD, 1, 0, 0);
    add_vec(1, 8'hEE, 0, 0,  0, 1, 8'hDD, 0, 0, 0);
    add_vec(0, 8'hEE, 0, 0,  0, 1, 8'hDD, 0, 0, 0);
    add_vec(0, 8'hEE, 1, 0,  1, 1, 8'hEE, 1, 0, 0);
    add_vec(0, 8'hEE, 0, 0,  0, 1, 8'hEE, 0, 0, 0);
    add_vec(0, 8'hEE, 1, 0,  0, 0, 8'hEE, 0, 0, 0);

    repeat (3) @(negedge clk);
    cmp_all("reset");
    rst = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      bif_a.bus_enable = vq[i].be;
      bif_a.unsync_bus = vq[i].bus;
      bif_a.sync_ready = vq[i].rdy;
      bif_a.ovr_clr    = vq[i].clr;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d_pulse", i + 1), int'(bif_a.enable_pulse), int'(vq[i].pulse));
      chk($sformatf("vec%0d_valid", i + 1), int'(bif_a.sync_valid),   int'(vq[i].valid));
      chk($sformatf("vec%0d_bus", i + 1),   int'(bif_a.sync_bus),     int'(vq[i].q));
      chk($sformatf("vec%0d_ack", i + 1),   int'(bif_a.ack),          int'(vq[i].ack));
      chk($sformatf("vec%0d_ovr", i + 1),   int'(bif_a.overrun),      int'(vq[i].ovr));
      chk($sformatf("vec%0d_cnt", i + 1),   int'(bif_a.ovr_count),    vq[i].cnt);
    end

    // Toggle mode, 4 stages: every change is one event, 5 edges later.
    bif_b.sync_ready = 1;
    lvl_b = 0;
    for (int k = 0; k < 3; k++) begin
      lvl_b = !lvl_b;
      bif_b.bus_enable = lvl_b;
      bif_b.unsync_bus = tdat[k];
      first_b = 0;
      n_b = 0;
      for (int e = 1; e <= 8; e++) begin
        @(posedge clk);
        @(negedge clk);
        if (bif_b.enable_pulse) begin
          n_b++;
          if (first_b == 0) first_b = e;
        end
      end
      chk($sformatf("tog%0d_latency", k), first_b, 5);
      chk($sformatf("tog%0d_npulse", k), n_b, 1);
      chk($sformatf("tog%0d_bus", k), int'(bif_b.sync_bus), int'(tdat[k]));
      chk($sformatf("tog%0d_ack", k), int'(bif_b.ack), int'(lvl_b));
      chk($sformatf("tog%0d_valid", k), int'(bif_b.sync_valid), 0);
    end

    // Back-to-back toggles with no consumer: 2-bit counter saturates at 3.
    for (int e = 1; e <= 10; e++) begin
      if (e <= 6) bif_c.bus_enable = ~bif_c.bus_enable;
      bif_c.unsync_bus = 8'(e);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("sat_cnt_e%0d", e), int'(bif_c.ovr_count), sat_cnt[e-1]);
      chk($sformatf("sat_pulse_e%0d", e), int'(bif_c.enable_pulse), int'(e >= 4 && e <= 9));
    end
    chk("sat_bus", int'(bif_c.sync_bus), 9);
    chk("sat_ovr", int'(bif_c.overrun), 1);

    bif_c.bus_enable = ~bif_c.bus_enable;
    for (int e = 1; e <= 4; e++) begin
      bif_c.ovr_clr = (e == 4);
      @(posedge clk);
      @(negedge clk);
    end
    bif_c.ovr_clr = 0;
    chk("clr_coinc_pulse", int'(bif_c.enable_pulse), 1);
    chk("clr_coinc_ovr", int'(bif_c.overrun), 1);
    chk("clr_coinc_cnt", int'(bif_c.ovr_count), 1);
    bif_c.ovr_clr = 1;
    @(posedge clk);
    @(negedge clk);
    bif_c.ovr_clr = 0;
    chk("clr_alone_ovr", int'(bif_c.overrun), 0);
    chk("clr_alone_cnt", int'(bif_c.ovr_count), 0);

    // Async reset while A holds data, then release with bus_enable already high.
    bif_a.bus_enable = 1;
    bif_a.unsync_bus = 8'h77;
    bif_a.sync_ready = 0;
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("hold_valid", int'(bif_a.sync_valid), 1);
    chk("hold_bus", int'(bif_a.sync_bus), 8'h77);
    bif_b.unsync_bus = 8'h44;
    #2;
    rst = 1'b1;
    #1;
    cmp_all("arst");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    first_a = 0; n_a = 0; first_b = 0; n_b = 0;
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (bif_a.enable_pulse) begin
        n_a++;
        if (first_a == 0) first_a = e;
      end
      if (bif_b.enable_pulse) begin
        n_b++;
        if (first_b == 0) first_b = e;
      end
    end
    chk("postrst_a_latency", first_a, 3);
    chk("postrst_a_npulse", n_a, 1);
    chk("postrst_a_bus", int'(bif_a.sync_bus), 8'h77);
    chk("postrst_b_latency", first_b, 5);
    chk("postrst_b_npulse", n_b, 1);
    chk("postrst_b_bus", int'(bif_b.sync_bus), 8'h44);

    // Random traffic against the reference model.
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ma = mdl_zero();
    mb = mdl_zero();
    mc = mdl_zero();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      cmp("rnd_a", ma, bif_a.sync_bus, bif_a.enable_pulse, bif_a.sync_valid, bif_a.ack,
          bif_a.overrun, int'(bif_a.ovr_count));
      cmp("rnd_b", mb, bif_b.sync_bus, bif_b.enable_pulse, bif_b.sync_valid, bif_b.ack,
          bif_b.overrun, int'(bif_b.ovr_count));
      cmp("rnd_c", mc, bif_c.sync_bus, bif_c.enable_pulse, bif_c.sync_valid, bif_c.ack,
          bif_c.overrun, int'(bif_c.ovr_count));
      if ($urandom_range(3) == 0) bif_a.bus_enable = ~bif_a.bus_enable;
      if ($urandom_range(3) == 0) bif_b.bus_enable = ~bif_b.bus_enable;
      if ($urandom_range(2) == 0) bif_c.bus_enable = ~bif_c.bus_enable;
      bif_a.unsync_bus = 8'($urandom);
      bif_b.unsync_bus = 8'($urandom);
      bif_c.unsync_bus = 8'($urandom);
      bif_a.sync_ready = ($urandom_range(2) == 0);
      bif_b.sync_ready = ($urandom_range(2) == 0);
      bif_c.sync_ready = ($urandom_range(3) == 0);
      bif_a.ovr_clr = ($urandom_range(15) == 0);
      bif_b.ovr_clr = ($urandom_range(15) == 0);
      bif_c.ovr_clr = ($urandom_range(15) == 0);
      ma = mdl_step(ma, 2, 0, 15, bif_a.bus_enable, bif_a.unsync_bus, bif_a.sync_ready, bif_a.ovr_clr);
      mb = mdl_step(mb, 4, 1, 15, bif_b.bus_enable, bif_b.unsync_bus, bif_b.sync_ready, bif_b.ovr_clr);
      mc = mdl_step(mc, 3, 1, 3, bif_c.bus_enable, bif_c.unsync_bus, bif_c.sync_ready, bif_c.ovr_clr);
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
